// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit slice
//
// Purpose: frame/data widths, bit_cnt landmarks, transmit FSM state type and
// the frame builder used by the transmit sequencer.
// Ports: none (package).
package uart_pkg;

    localparam int UART_DATA_W  = 8;
    localparam int UART_FRAME_W = 10;

    localparam logic [3:0] BIT_CNT_START = 4'd0;
    localparam logic [3:0] BIT_CNT_STOP  = 4'd9;
    // Out of the 0..9 range on purpose: selects the mux default branch (line high).
    localparam logic [3:0] BIT_CNT_IDLE  = 4'd15;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    // Bit 0 is the start bit (0), bit 9 the stop bit (1), data LSB first between.
    function automatic logic [UART_FRAME_W-1:0] make_frame(input logic [UART_DATA_W-1:0] data);
        return {1'b1, data, 1'b0};
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// rtl/uart_tx_ctrl_if.sv - byte handshake between a producer and the UART transmit sequencer
//
// Purpose: groups the valid/ready byte handshake.
// Signals: tx_data  byte to send, LSB first
//          tx_valid tx_data valid
//          tx_ready sequencer can accept a byte this cycle
// Modports: master (byte producer), slave (uart_tx_ctrl).
interface uart_tx_ctrl_if;
    import uart_pkg::*;

    logic [UART_DATA_W-1:0] tx_data;
    logic                   tx_valid;
    logic                   tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);

endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period timer for the UART transmit sequencer
//
// Purpose: counts clocks while enabled and flags the last clock of each bit period.
// Ports: clk  system clock
//        rst  synchronous active-high reset
//        en   count enable; the counter restarts from 0 whenever en is low
//        tick high on the last clock of each CLKS_PER_BIT-long period
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    if (CLKS_PER_BIT < 2) begin : g_bad_rate
        $error("uart_baud_gen: CLKS_PER_BIT must be >= 2");
    end

    logic [CNT_W-1:0] baud_cnt;

    assign tick = en && (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            baud_cnt <= '0;
        end else if (tick) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit sequencer feeding the 10:1 bit-select mux
//
// Purpose: accepts a byte, builds the 10-bit frame and steps bit_cnt 0..9 at the
// baud rate; parks bit_cnt at 15 between frames so the mux idles the line high.
// Optional: UART_TX_HOLD_EN adds a one-entry hold register for back-to-back frames.
// Ports: clk      system clock
//        rst      synchronous active-high reset
//        tx_if    byte handshake (slave modport: tx_data, tx_valid in; tx_ready out)
//        frame    {stop, data[7:0], start} to the mux
//        bit_cnt  mux select: 0..9 while sending, 15 when idle
//        tx_busy  frame in progress
//        tx_done  one-cycle pulse after the stop-bit period ends
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_tx_ctrl_if.slave           tx_if,
    output logic [UART_FRAME_W-1:0] frame,
    output logic [3:0]              bit_cnt,
    output logic                    tx_busy,
    output logic                    tx_done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

    tx_state_t               state, state_nxt;
    logic [UART_FRAME_W-1:0] frame_nxt;
    logic [3:0]              bit_cnt_nxt;
    logic                    ready_nxt, busy_nxt, done_nxt;
    logic                    accept, tick;

`ifdef UART_TX_HOLD_EN
    logic [UART_DATA_W-1:0]  hold_data, hold_data_nxt;
    logic                    hold_full, hold_full_nxt;
`endif

    assign accept = tx_if.tx_valid && tx_if.tx_ready;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state == SEND),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            frame          <= '1;
            bit_cnt        <= BIT_CNT_IDLE;
            tx_if.tx_ready <= 1'b1;
            tx_busy        <= 1'b0;
            tx_done        <= 1'b0;
`ifdef UART_TX_HOLD_EN
            hold_data      <= '0;
            hold_full      <= 1'b0;
`endif
        end else begin
            state          <= state_nxt;
            frame          <= frame_nxt;
            bit_cnt        <= bit_cnt_nxt;
            tx_if.tx_ready <= ready_nxt;
            tx_busy        <= busy_nxt;
            tx_done        <= done_nxt;
`ifdef UART_TX_HOLD_EN
            hold_data      <= hold_data_nxt;
            hold_full      <= hold_full_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        frame_nxt   = frame;
        bit_cnt_nxt = bit_cnt;
        ready_nxt   = tx_if.tx_ready;
        busy_nxt    = tx_busy;
        done_nxt    = 1'b0;
`ifdef UART_TX_HOLD_EN
        hold_data_nxt = hold_data;
        hold_full_nxt = hold_full;
`endif
        unique case (state)
            IDLE: begin
                ready_nxt = 1'b1;
                if (accept) begin
                    frame_nxt   = make_frame(tx_if.tx_data);
                    bit_cnt_nxt = BIT_CNT_START;
                    busy_nxt    = 1'b1;
                    state_nxt   = SEND;
`ifdef UART_TX_HOLD_EN
                    ready_nxt   = 1'b1;
`else
                    ready_nxt   = 1'b0;
`endif
                end
            end
            SEND: begin
`ifdef UART_TX_HOLD_EN
                // A byte accepted mid-frame parks in the hold register; one
                // accepted on the stop-bit tick is started directly below.
                if (accept && !(tick && bit_cnt == BIT_CNT_STOP)) begin
                    hold_data_nxt = tx_if.tx_data;
                    hold_full_nxt = 1'b1;
                    ready_nxt     = 1'b0;
                end
`endif
                if (tick) begin
                    if (bit_cnt != BIT_CNT_STOP) begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else begin
                        done_nxt = 1'b1;
`ifdef UART_TX_HOLD_EN
                        if (hold_full) begin
                            frame_nxt     = make_frame(hold_data);
                            bit_cnt_nxt   = BIT_CNT_START;
                            hold_full_nxt = 1'b0;
                            ready_nxt     = 1'b1;
                        end else if (accept) begin
                            frame_nxt     = make_frame(tx_if.tx_data);
                            bit_cnt_nxt   = BIT_CNT_START;
                            ready_nxt     = 1'b1;
                        end else begin
                            bit_cnt_nxt   = BIT_CNT_IDLE;
                            busy_nxt      = 1'b0;
                            ready_nxt     = 1'b1;
                            state_nxt     = IDLE;
                        end
`else
                        bit_cnt_nxt = BIT_CNT_IDLE;
                        busy_nxt    = 1'b0;
                        ready_nxt   = 1'b1;
                        state_nxt   = IDLE;
`endif
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
